mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: legal byte-lane masks,
// controller state encoding and a helper that classifies access types.
package mem_arbiter_pkg;

    localparam logic [3:0] BYTE        = 4'b0001;
    localparam logic [3:0] HALFWORD    = 4'b0011;
    localparam logic [3:0] THREEQUATER = 4'b0111;
    localparam logic [3:0] FULLWORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // True when the mask is one of the contiguous low-aligned lane patterns.
    function automatic logic type_legal(input logic [3:0] t);
        return (t == BYTE) || (t == HALFWORD) ||
               (t == THREEQUATER) || (t == FULLWORD);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester channel: request/grant, request payload and response.
// The master side is the requesting core, the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int W = 32,
    parameter int L = 4
);
    logic         req;
    logic         gnt;
    logic         we;
    logic [L-1:0] mtype;
    logic [W-1:0] addr;
    logic [W-1:0] wdat;
    logic         sign;
    logic         rvalid;
    logic         rready;
    logic [W-1:0] rdata;
    logic         err;

    modport master (
        output req, we, mtype, addr, wdat, sign, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, mtype, addr, wdat, sign, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational on the request
// vector; the priority pointer advances only when the grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // Lone requester wins outright; on contention the pointer decides,
    // and after a taken grant the pointer moves to the loser.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (take && (req != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    // Pointer register, favours requester 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Each access is IDLE (grant) -> ACCESS
// (one RAM cycle) -> RESP (held until the owner takes the response).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int w = 32,
    parameter int l = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave m0,
    mem_arbiter_if.slave m1,
    output logic [w-1:0] ram_addr,
    output logic [w-1:0] ram_wdat,
    output logic [l-1:0] ram_type,
    output logic         ram_we,
    output logic         ram_re,
    output logic         sign,
    input  logic [w-1:0] data_reg
);

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         we_q, we_d;
    logic [l-1:0] type_q, type_d;
    logic [w-1:0] addr_q, addr_d;
    logic [w-1:0] wdat_q, wdat_d;
    logic         sign_q, sign_d;
    logic         ram_we_q, ram_we_d;
    logic         ram_re_q, ram_re_d;
    logic [1:0]   rvalid_q, rvalid_d;
    logic [w-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [1:0]   arb_req, arb_gnt;
    logic         in_idle;
    logic         sel_we, sel_sign, sel_legal;
    logic [l-1:0] sel_type;
    logic [w-1:0] sel_addr, sel_wdat;
    logic         owner_rready;

    assign in_idle = (state_q == IDLE);
    assign arb_req = {m1.req, m0.req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .take  (in_idle),
        .gnt   (arb_gnt)
    );

    assign m0.gnt = in_idle & arb_gnt[0];
    assign m1.gnt = in_idle & arb_gnt[1];

    // Payload mux for the requester being granted this cycle.
    always_comb begin
        sel_we       = arb_gnt[1] ? m1.we    : m0.we;
        sel_type     = arb_gnt[1] ? m1.mtype : m0.mtype;
        sel_addr     = arb_gnt[1] ? m1.addr  : m0.addr;
        sel_wdat     = arb_gnt[1] ? m1.wdat  : m0.wdat;
        sel_sign     = arb_gnt[1] ? m1.sign  : m0.sign;
        sel_legal    = type_legal(sel_type);
        owner_rready = owner_q ? m1.rready : m0.rready;
    end

    // Next-state and datapath update for the access controller.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        sign_d   = sign_q;
        ram_we_d = 1'b0;
        ram_re_d = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    owner_d  = arb_gnt[1];
                    we_d     = sel_we;
                    type_d   = sel_type;
                    addr_d   = sel_addr;
                    wdat_d   = sel_wdat;
                    sign_d   = sel_sign;
                    ram_we_d = sel_legal & sel_we;
                    ram_re_d = sel_legal & ~sel_we;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d           = (type_legal(type_q) && !we_q) ? data_reg : '0;
                err_d             = ~type_legal(type_q);
                rvalid_d          = '0;
                rvalid_d[owner_q] = 1'b1;
                state_d           = RESP;
            end
            RESP: begin
                if (owner_rready) begin
                    rvalid_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers, synchronously cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            type_q   <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            sign_q   <= 1'b0;
            ram_we_q <= 1'b0;
            ram_re_q <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            sign_q   <= sign_d;
            ram_we_q <= ram_we_d;
            ram_re_q <= ram_re_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Strobes are gated by rst_n so a reset landing on the ACCESS edge
    // keeps the RAM from committing the write.
    assign ram_we   = ram_we_q & rst_n;
    assign ram_re   = ram_re_q & rst_n;
    assign ram_addr = addr_q;
    assign ram_wdat = wdat_q;
    assign ram_type = type_q;
    assign sign     = sign_q;

    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.err    = rvalid_q[0] & err_q;
    assign m1.err    = rvalid_q[1] & err_q;
    assign m0.rdata  = rvalid_q[0] ? rdata_q : '0;
    assign m1.rdata  = rvalid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a little-endian byte RAM model
// that applies the lane mask and sign extension on reads.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ram_addr, ram_wdat, data_reg;
    logic [3:0]  ram_type;
    logic        ram_we, ram_re, sign;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0]    mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    mem_arbiter_if #(.W(32), .L(4)) m0_if ();
    mem_arbiter_if #(.W(32), .L(4)) m1_if ();

    mem_arbiter #(.w(32), .l(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_addr (ram_addr),
        .ram_wdat (ram_wdat),
        .ram_type (ram_type),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .sign     (sign),
        .data_reg (data_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
    endfunction

    // RAM read path: combinational, lane-masked, optional sign extension.
    always_comb begin
        logic [31:0] wd;
        wd = mem_word(ram_addr[7:0]);
        case (ram_type)
            4'b0001: data_reg = sign ? {{24{wd[7]}},  wd[7:0]}  : {24'd0, wd[7:0]};
            4'b0011: data_reg = sign ? {{16{wd[15]}}, wd[15:0]} : {16'd0, wd[15:0]};
            4'b0111: data_reg = sign ? {{8{wd[23]}},  wd[23:0]} : {8'd0, wd[23:0]};
            4'b1111: data_reg = wd;
            default: data_reg = '0;
        endcase
    end

    // RAM write path plus a backdoor for preloading.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bd_we) begin
                mem[8'(bd_addr + 8'(k))] <= bd_data[8*k +: 8];
            end else if (ram_we && ram_type[k]) begin
                mem[8'(ram_addr[7:0] + 8'(k))] <= ram_wdat[8*k +: 8];
            end
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic rq, input logic we, input logic [3:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdat, input logic sgn);
        if (idx == 0) begin
            m0_if.req = rq; m0_if.we = we; m0_if.mtype = typ;
            m0_if.addr = addr; m0_if.wdat = wdat; m0_if.sign = sgn;
        end else begin
            m1_if.req = rq; m1_if.we = we; m1_if.mtype = typ;
            m1_if.addr = addr; m1_if.wdat = wdat; m1_if.sign = sgn;
        end
    endtask

    task automatic set_req(input int idx, input logic v);
        if (idx == 0) m0_if.req = v; else m1_if.req = v;
    endtask

    task automatic set_rready(input int idx, input logic v);
        if (idx == 0) m0_if.rready = v; else m1_if.rready = v;
    endtask

    function automatic logic get_gnt(input int idx);
        return (idx == 0) ? m0_if.gnt : m1_if.gnt;
    endfunction
    function automatic logic get_rvalid(input int idx);
        return (idx == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction
    function automatic logic get_err(input int idx);
        return (idx == 0) ? m0_if.err : m1_if.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int idx);
        return (idx == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    // Full uncontended transaction: grant, ACCESS, RESP, back to IDLE.
    task automatic run_txn(input string tag, input int idx, input logic we, input logic [3:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdat, input logic sgn,
                           input logic [31:0] exp_rdata);
        logic legal;
        legal = (typ == 4'b0001) || (typ == 4'b0011) || (typ == 4'b0111) || (typ == 4'b1111);
        @(negedge clk);
        drive(idx, 1'b1, we, typ, addr, wdat, sgn);
        set_rready(idx, 1'b0);
        #1;
        chk1({tag, " gnt"}, get_gnt(idx), 1'b1);
        chk1({tag, " other gnt"}, get_gnt(1 - idx), 1'b0);
        @(negedge clk);
        set_req(idx, 1'b0);
        #1;
        chk1({tag, " access ram_we"}, ram_we, legal & we);
        chk1({tag, " access ram_re"}, ram_re, legal & ~we);
        chk32({tag, " access ram_addr"}, ram_addr, addr);
        chk32({tag, " access ram_wdat"}, ram_wdat, wdat);
        chk32({tag, " access ram_type"}, 32'(ram_type), 32'(typ));
        chk1({tag, " access sign"}, sign, sgn);
        chk1({tag, " access rvalid"}, get_rvalid(idx), 1'b0);
        @(negedge clk);
        #1;
        chk1({tag, " resp rvalid"}, get_rvalid(idx), 1'b1);
        chk32({tag, " resp rdata"}, get_rdata(idx), exp_rdata);
        chk1({tag, " resp err"}, get_err(idx), ~legal);
        chk1({tag, " resp other rvalid"}, get_rvalid(1 - idx), 1'b0);
        chk1({tag, " resp ram_we"}, ram_we, 1'b0);
        chk1({tag, " resp ram_re"}, ram_re, 1'b0);
        set_rready(idx, 1'b1);
        @(negedge clk);
        #1;
        chk1({tag, " idle rvalid"}, get_rvalid(idx), 1'b0);
        set_rready(idx, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0);
        m0_if.rready = 1'b0;
        m1_if.rready = 1'b0;

        // Preload RAM during reset
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 8'h10; bd_data = 32'hDEADBEEF;
        @(negedge clk);
        bd_addr = 8'h30; bd_data = 32'h11223344;
        @(negedge clk);
        bd_we = 1'b0;
        #1;
        chk1("reset m0 gnt", m0_if.gnt, 1'b0);
        chk1("reset m0 rvalid", m0_if.rvalid, 1'b0);
        chk1("reset m1 rvalid", m1_if.rvalid, 1'b0);
        chk1("reset m0 err", m0_if.err, 1'b0);
        chk1("reset ram_we", ram_we, 1'b0);
        chk1("reset ram_re", ram_re, 1'b0);
        chk32("reset ram_addr", ram_addr, 32'h0);
        chk32("reset ram_wdat", ram_wdat, 32'h0);
        rst_n = 1'b1;

        // Single read of the preloaded word
        run_txn("rd0", 0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Contention straight out of reset: m0, then m1, then m0 again
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0);
        m0_if.rready = 1'b1; m1_if.rready = 1'b1;
        #1;
        chk1("cont1 m0 gnt", m0_if.gnt, 1'b1);
        chk1("cont1 m1 gnt", m1_if.gnt, 1'b0);
        @(negedge clk); #1;
        chk1("cont1 access m1 gnt", m1_if.gnt, 1'b0);
        chk1("cont1 access m0 gnt", m0_if.gnt, 1'b0);
        @(negedge clk); #1;
        chk1("cont1 resp m0 rvalid", m0_if.rvalid, 1'b1);
        chk1("cont1 resp m1 gnt", m1_if.gnt, 1'b0);
        @(negedge clk); #1;
        chk1("cont2 m1 gnt", m1_if.gnt, 1'b1);
        chk1("cont2 m0 gnt", m0_if.gnt, 1'b0);
        @(negedge clk);
        @(negedge clk); #1;
        chk1("cont2 resp m1 rvalid", m1_if.rvalid, 1'b1);
        chk32("cont2 resp m1 rdata", m1_if.rdata, 32'hDEADBEEF);
        chk1("cont2 resp m0 rvalid", m0_if.rvalid, 1'b0);
        @(negedge clk); #1;
        chk1("cont3 m0 gnt", m0_if.gnt, 1'b1);
        chk1("cont3 m1 gnt", m1_if.gnt, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0);
        @(negedge clk); #1;
        chk1("cont3 resp m0 rvalid", m0_if.rvalid, 1'b1);
        @(negedge clk);
        m0_if.rready = 1'b0; m1_if.rready = 1'b0;

        // Write a byte, then read it back signed and unsigned
        run_txn("wr_b", 1, 1'b1, 4'b0001, 32'h20, 32'h000000A5, 1'b0, 32'h0);
        run_txn("rd_sb", 1, 1'b0, 4'b0001, 32'h20, 32'h0, 1'b1, 32'hFFFFFFA5);
        run_txn("rd_ub", 1, 1'b0, 4'b0001, 32'h20, 32'h0, 1'b0, 32'h000000A5);
        run_txn("rd_sh", 0, 1'b0, 4'b0011, 32'h10, 32'h0, 1'b1, 32'hFFFFBEEF);

        // Illegal lane mask: granted, no RAM strobe, error response
        run_txn("ill", 1, 1'b1, 4'b0101, 32'h40, 32'h00001234, 1'b0, 32'h0);

        // Response backpressure with m1 waiting
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0);
        m0_if.rready = 1'b0;
        #1;
        chk1("bp m0 gnt", m0_if.gnt, 1'b1);
        @(negedge clk);
        set_req(0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) drive(1, 1'b1, 1'b0, 4'b1111, 32'h30, 32'h0, 1'b0);
            #1;
            chk1($sformatf("bp rvalid c%0d", c), m0_if.rvalid, 1'b1);
            chk32($sformatf("bp rdata c%0d", c), m0_if.rdata, 32'hDEADBEEF);
            chk1($sformatf("bp m1 gnt c%0d", c), m1_if.gnt, 1'b0);
        end
        @(negedge clk);
        m0_if.rready = 1'b1;
        #1;
        chk1("bp last rvalid", m0_if.rvalid, 1'b1);
        chk1("bp last m1 gnt", m1_if.gnt, 1'b0);
        @(negedge clk);
        m0_if.rready = 1'b0;
        #1;
        chk1("bp m1 gnt idle", m1_if.gnt, 1'b1);
        chk1("bp m0 rvalid idle", m0_if.rvalid, 1'b0);
        @(negedge clk);
        set_req(1, 1'b0);
        m1_if.rready = 1'b1;
        @(negedge clk); #1;
        chk32("bp m1 rdata", m1_if.rdata, 32'h11223344);
        @(negedge clk);
        m1_if.rready = 1'b0;

        // Reset landing on ACCESS of a write to 0x30
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'b1111, 32'h30, 32'hCAFEF00D, 1'b0);
        #1;
        chk1("rstacc gnt", m0_if.gnt, 1'b1);
        @(negedge clk);
        set_req(0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rstacc ram_we", ram_we, 1'b0);
        @(negedge clk); #1;
        chk32("rstacc mem", mem_word(8'h30), 32'h11223344);
        chk1("rstacc rvalid", m0_if.rvalid, 1'b0);
        chk1("rstacc err", m0_if.err, 1'b0);
        chk32("rstacc ram_addr", ram_addr, 32'h0);
        chk32("rstacc ram_wdat", ram_wdat, 32'h0);
        chk32("rstacc ram_type", 32'(ram_type), 32'h0);
        chk1("rstacc sign", sign, 1'b0);
        rst_n = 1'b1;

        // Reset during RESP drops the pending response
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        set_req(0, 1'b0);
        @(negedge clk); #1;
        chk1("rstresp rvalid before", m0_if.rvalid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk1("rstresp rvalid after", m0_if.rvalid, 1'b0);
        chk1("rstresp err after", m0_if.err, 1'b0);
        rst_n = 1'b1;
        run_txn("post_rst", 1, 1'b0, 4'b0111, 32'h10, 32'h0, 1'b1, 32'hFFADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
